int_ctrl: RTL and testbench

- Memory-mapped interrupt controller between the interrupt sources (Timer0 IRQ, Timer1 IRQ, external interrupt, three spare lines) and the CPU's interrupt input.
- Latches and masks requests, selects the highest-priority one, and raises a single request with a vector.
- Sequences each interrupt through request, acknowledge and return; one interrupt is serviced at a time.
- Sits on the bridge as an additional word-addressed slave, alongside the timers.

---
 rtl/int_ctrl.sv | 176 +++++++++++++++++
 tb/tb_int_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_ctrl.sv
// int_ctrl: memory-mapped interrupt controller.
//   Latches / masks N_SRC interrupt lines, picks the lowest-index eligible
//   source and sequences it through request -> ack -> eret, one at a time.
//   Optional macro INT_CTRL_STATS_EN adds per-source 16-bit accept counters.
// Ports:
//   clk, reset      : clock, async active-high reset
//   src[N_SRC]      : raw interrupt lines (bit0 = highest priority)
//   Addr/WE/Din     : word-offset register write port
//   Dout            : combinational register read data for Addr
//   irq/vec         : registered request and source index to the CPU
//   ack/eret        : CPU handler entry / return pulses
// Register map: 0 PEND (W1C, edge bits), 1 MASK, 2 MODE (1=edge),
//   3 STATUS {state,busy,0}, 4+i CNT[i] (stats), write 0xF clears CNTs.

// Per-source pending cell: keeps the line history and the edge latch.
module int_ctrl_src (
  input  logic clk,
  input  logic reset,
  input  logic line,
  input  logic edge_mode,
  input  logic clr,
  output logic pend
);
  logic line_q, edg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      line_q <= 1'b0;
      edg    <= 1'b0;
    end else begin
      line_q <= line;
      // latch is held clear in level mode so a mode flip never exposes stale edges
      if (!edge_mode)          edg <= 1'b0;
      else if (line & ~line_q) edg <= 1'b1;  // set beats clear
      else if (clr)            edg <= 1'b0;
    end
  end

  assign pend = edge_mode ? edg : line;
endmodule

module int_ctrl #(
  parameter int N_SRC = 6,
  parameter int VEC_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] src,
  input  logic [3:0]       Addr,
  input  logic             WE,
  input  logic [31:0]      Din,
  output logic [31:0]      Dout,
  output logic             irq,
  output logic [VEC_W-1:0] vec,
  input  logic             ack,
  input  logic             eret
);
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, SERV = 2'd2} state_t;

  state_t           state, state_nx;
  logic             irq_nx;
  logic [VEC_W-1:0] vec_nx, sel;
  logic [N_SRC-1:0] mask, mode, pend, elig, clr, elig_sh;
  logic             ack_ok, cur_elig, busy;

  assign ack_ok   = (state == REQ) && ack;
  assign elig     = pend & mask;
  assign elig_sh  = elig >> vec;
  assign cur_elig = elig_sh[0];
  assign busy     = (state != IDLE);

  for (genvar i = 0; i < N_SRC; i++) begin : g_src
    assign clr[i] = (WE && Addr == 4'h0 && Din[i]) ||
                    (ack_ok && vec == VEC_W'(i));
    int_ctrl_src u_src (
      .clk      (clk),
      .reset    (reset),
      .line     (src[i]),
      .edge_mode(mode[i]),
      .clr      (clr[i]),
      .pend     (pend[i])
    );
  end

  // lowest set index wins
  always_comb begin
    sel = '0;
    for (int i = N_SRC - 1; i >= 0; i--)
      if (elig[i]) sel = VEC_W'(i);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask <= '0;
      mode <= '0;
    end else if (WE) begin
      if (Addr == 4'h1) mask <= Din[N_SRC-1:0];
      if (Addr == 4'h2) mode <= Din[N_SRC-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      irq   <= 1'b0;
      vec   <= '0;
    end else begin
      state <= state_nx;
      irq   <= irq_nx;
      vec   <= vec_nx;
    end
  end

  always_comb begin
    state_nx = state;
    irq_nx   = irq;
    vec_nx   = vec;
    case (state)
      IDLE: begin
        irq_nx = 1'b0;
        if (|elig) begin
          state_nx = REQ;
          irq_nx   = 1'b1;
          vec_nx   = sel;
        end
      end
      REQ: begin
        // ack beats a same-cycle withdrawal
        if (ack) begin
          state_nx = SERV;
          irq_nx   = 1'b0;
        end else if (!cur_elig) begin
          state_nx = IDLE;
          irq_nx   = 1'b0;
        end
      end
      SERV: begin
        irq_nx = 1'b0;
        if (eret) state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
        irq_nx   = 1'b0;
      end
    endcase
  end

`ifdef INT_CTRL_STATS_EN
  logic [N_SRC-1:0][15:0] cnt;

  for (genvar i = 0; i < N_SRC; i++) begin : g_cnt
    always_ff @(posedge clk or posedge reset) begin
      if (reset)                                       cnt[i] <= '0;
      else if (WE && Addr == 4'hF)                     cnt[i] <= '0;
      else if (ack_ok && vec == VEC_W'(i) && cnt[i] != 16'hFFFF)
                                                       cnt[i] <= cnt[i] + 16'd1;
    end
  end
`endif

  always_comb begin
    Dout = '0;
    case (Addr)
      4'h0: Dout[N_SRC-1:0] = pend;
      4'h1: Dout[N_SRC-1:0] = mask;
      4'h2: Dout[N_SRC-1:0] = mode;
      4'h3: Dout[3:0]       = {state, busy, 1'b0};
      default: begin
`ifdef INT_CTRL_STATS_EN
        for (int i = 0; i < N_SRC; i++)
          if (Addr == 4'(4 + i)) Dout[15:0] = cnt[i];
`endif
      end
    endcase
  end
endmodule

// File: tb/tb_int_ctrl.sv
// Bench for int_ctrl: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural model.
module tb_int_ctrl;
  localparam int N = 6;
  localparam int VW = 3;

  logic          clk = 1'b0, reset = 1'b1;
  logic [N-1:0]  src = '0;
  logic [3:0]    Addr = '0;
  logic          WE = 1'b0;
  logic [31:0]   Din = '0;
  logic          ack = 1'b0, eret = 1'b0;
  wire  [31:0]   Dout;
  wire           irq;
  wire  [VW-1:0] vec;

  int checks = 0, failures = 0;
  bit cmp_en = 1'b0;

  int_ctrl #(.N_SRC(N), .VEC_W(VW)) dut (
    .clk(clk), .reset(reset), .src(src), .Addr(Addr), .WE(WE), .Din(Din),
    .Dout(Dout), .irq(irq), .vec(vec), .ack(ack), .eret(eret)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", n, a, e, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 idle, 1 requesting, 2 in service
  bit           m_edge[N];
  logic [N-1:0] m_mask, m_mode, m_srcq;
  int           m_phase, m_vec, m_cnt[N];
  bit           m_irq;

  function automatic logic [N-1:0] m_pend();
    logic [N-1:0] p;
    for (int i = 0; i < N; i++) p[i] = m_mode[i] ? m_edge[i] : src[i];
    return p;
  endfunction

  function automatic logic [31:0] m_read(input logic [3:0] a);
    logic [31:0] r;
    logic [1:0]  ph;
    r  = '0;
    ph = m_phase[1:0];
    case (a)
      4'h0: r[N-1:0] = m_pend();
      4'h1: r[N-1:0] = m_mask;
      4'h2: r[N-1:0] = m_mode;
      4'h3: r[3:0]   = {ph, (m_phase != 0), 1'b0};
      default: begin
`ifdef INT_CTRL_STATS_EN
        if (int'(a) >= 4 && int'(a) < 4 + N) r = 32'(m_cnt[int'(a) - 4]);
`endif
      end
    endcase
    return r;
  endfunction

  always @(posedge clk or posedge reset) begin
    logic [N-1:0] el, rise;
    bit ackt;
    if (reset) begin
      for (int i = 0; i < N; i++) begin m_edge[i] = 0; m_cnt[i] = 0; end
      m_mask = '0; m_mode = '0; m_srcq = '0;
      m_phase = 0; m_vec = 0; m_irq = 0;
    end else begin
      el   = m_pend() & m_mask;
      rise = src & ~m_srcq;
      ackt = ack && (m_phase == 1);
      for (int i = 0; i < N; i++) begin
        if (!m_mode[i])                                            m_edge[i] = 0;
        else if (rise[i])                                          m_edge[i] = 1;
        else if ((WE && Addr == 0 && Din[i]) || (ackt && m_vec == i)) m_edge[i] = 0;
      end
      if (WE && Addr == 4'hF)
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
      else if (ackt && m_cnt[m_vec] < 65535)
        m_cnt[m_vec]++;
      if (m_phase == 0) begin
        if (el != 0) begin
          m_phase = 1;
          for (int i = N - 1; i >= 0; i--) if (el[i]) m_vec = i;
        end
      end else if (m_phase == 1) begin
        if (ack)             m_phase = 2;
        else if (!el[m_vec]) m_phase = 0;
      end else if (eret) begin
        m_phase = 0;
      end
      m_irq = (m_phase == 1);
      if (WE && Addr == 4'h1) m_mask = Din[N-1:0];
      if (WE && Addr == 4'h2) m_mode = Din[N-1:0];
      m_srcq = src;
    end
  end

  always @(negedge clk) begin
    if (cmp_en && !reset) begin
      chk("m_irq", {31'b0, irq}, {31'b0, m_irq});
      chk("m_vec", {29'b0, vec}, 32'(m_vec));
      chk("m_dout", Dout, m_read(Addr));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    Addr = a; WE = 1'b1; Din = d;
    tick();
    WE = 1'b0; Din = '0;
  endtask

  task automatic rd(input string n, input logic [3:0] a, input logic [31:0] e);
    Addr = a; #1;
    chk(n, Dout, e);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    do_reset();
    cmp_en = 1'b1;
    rd("rst_pend", 4'h0, 32'h0);
    rd("rst_mask", 4'h1, 32'h0);
    rd("rst_status", 4'h3, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);

    // reset while requesting: irq drops without a clock
    wr(4'h1, 32'h1);
    src = 6'h01;
    tick();
    chk("lvl_req_irq", {31'b0, irq}, 32'h1);
    #1 reset = 1'b1; src = '0;
    #1 chk("async_rst_irq", {31'b0, irq}, 32'h0);
    #1 reset = 1'b0;
    tick();
    rd("post_rst_pend", 4'h0, 32'h0);
    rd("post_rst_mask", 4'h1, 32'h0);
    rd("post_rst_status", 4'h3, 32'h0);

    // edge pulse on src[1]
    wr(4'h2, 32'h3F);
    wr(4'h1, 32'h3F);
    src = 6'h02; tick(); src = '0;
    rd("e1_pend", 4'h0, 32'h02);
    chk("e1_irq_lat", {31'b0, irq}, 32'h0);
    tick();
    chk("e1_irq", {31'b0, irq}, 32'h1);
    chk("e1_vec", {29'b0, vec}, 32'h1);
    ack = 1'b1; tick(); ack = 1'b0;
    rd("e1_pend_ack", 4'h0, 32'h0);
    chk("e1_irq_ack", {31'b0, irq}, 32'h0);
    rd("e1_status_serv", 4'h3, 32'hA);
    eret = 1'b1; tick(); eret = 1'b0;
    rd("e1_status_idle", 4'h3, 32'h0);

    // simultaneous src[2] and src[0]
    src = 6'h05; tick(); src = '0;
    rd("pr_pend5", 4'h0, 32'h05);
    tick();
    chk("pr_vec0", {29'b0, vec}, 32'h0);
    ack = 1'b1; tick(); ack = 1'b0;
    rd("pr_pend4", 4'h0, 32'h04);
    eret = 1'b1; tick(); eret = 1'b0;
    chk("pr_irq_idle", {31'b0, irq}, 32'h0);
    tick();
    chk("pr_irq2", {31'b0, irq}, 32'h1);
    chk("pr_vec2", {29'b0, vec}, 32'h2);
    ack = 1'b1; tick(); ack = 1'b0;
    rd("pr_pend0", 4'h0, 32'h0);
    eret = 1'b1; tick(); eret = 1'b0;

    // event latched while in service
    src = 6'h01; tick(); src = '0;
    tick();
    ack = 1'b1; tick(); ack = 1'b0;
    src = 6'h08; tick(); src = '0;
    rd("sv_pend8", 4'h0, 32'h08);
    chk("sv_irq0", {31'b0, irq}, 32'h0);
    eret = 1'b1; tick(); eret = 1'b0;
    chk("sv_irq_eret", {31'b0, irq}, 32'h0);
    tick();
    chk("sv_irq3", {31'b0, irq}, 32'h1);
    chk("sv_vec3", {29'b0, vec}, 32'h3);
    ack = 1'b1; tick(); ack = 1'b0;
    eret = 1'b1; tick(); eret = 1'b0;

    // level withdrawal by mask
    wr(4'h2, 32'h0);
    wr(4'h1, 32'h1);
    src = 6'h01; tick();
    chk("lv_irq", {31'b0, irq}, 32'h1);
    chk("lv_vec", {29'b0, vec}, 32'h0);
    wr(4'h1, 32'h0);
    chk("lv_irq_oldmask", {31'b0, irq}, 32'h1);
    tick();
    chk("lv_irq_drop", {31'b0, irq}, 32'h0);
    rd("lv_status", 4'h3, 32'h0);
    wr(4'h0, 32'h1);
    rd("lv_w1c_ignored", 4'h0, 32'h1);
    src = '0; tick();

`ifdef INT_CTRL_STATS_EN
    do_reset();
    wr(4'h2, 32'h3F);
    wr(4'h1, 32'h3F);
    for (int k = 0; k < 3; k++) begin
      src = 6'h02; tick(); src = '0;
      tick();
      ack = 1'b1; tick(); ack = 1'b0;
      eret = 1'b1; tick(); eret = 1'b0;
    end
    rd("st_cnt1", 4'h5, 32'h3);
    rd("st_cnt0", 4'h4, 32'h0);
    wr(4'hF, 32'h0);
    rd("st_clr", 4'h5, 32'h0);
`else
    rd("nost_cnt", 4'h5, 32'h0);
`endif

    // randomized traffic
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 2) == 0) src = src ^ N'(1 << $urandom_range(0, N - 1));
      ack  = ($urandom_range(0, 3) == 0);
      eret = ($urandom_range(0, 4) == 0);
      WE   = ($urandom_range(0, 7) == 0);
      Din  = $urandom;
      case ($urandom_range(0, 5))
        0: Addr = 4'h0;
        1: Addr = 4'h1;
        2: Addr = 4'h2;
        3: Addr = 4'hF;
        default: Addr = 4'($urandom_range(0, 15));
      endcase
      if ($urandom_range(0, 399) == 0) begin
        #1 reset = 1'b1;
        #1 reset = 1'b0;
      end
      tick();
    end
    WE = 1'b0; ack = 1'b0; eret = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
